uart_fifo_core: RTL and testbench
=================================

# uart_fifo_core

Parametrised UART transceiver that succeeds the fixed 8N1 peripheral UART. It adds configurable word width, stop-bit count, optional parity and per-direction FIFOs. It sits between the board-level switch/button logic (or a bus bridge) and the `tx`/`rx` pins. A 16x oversampled receiver with mid-bit sampling replaces single-point sampling, and per-word error status travels with each received word.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency in Hz.
- `BAUD`, 9600: line rate.
- `DATA_W`, 8: data bits per frame, legal range 5..8.
- `STOP_BITS`, 1: stop bits transmitted, 1 or 2. The receiver checks only the first stop bit.
- `FIFO_DEPTH`, 16: entries per FIFO, power of two, at least 2.

Ports:
- `clk_in1`, in, 1: single system clock.
- `reset_pi`, in, 1: asynchronous, active-high reset.
- `tx_data_pi`, in, DATA_W: word to transmit.
- `tx_wr_pi`, in, 1: push `tx_data_pi` into the TX FIFO.
- `tx_full_po`, out, 1: TX FIFO full.
- `tx_busy_po`, out, 1: serializer not IDLE, or TX FIFO not empty.
- `rx_data_po`, out, DATA_W: head of RX FIFO, valid while `rx_empty_po` is 0.
- `rx_ferr_po`, out, 1: framing error flag of the head word.
- `rx_perr_po`, out, 1: parity error flag of the head word. Tied 0 without the parity macro.
- `rx_rd_pi`, in, 1: pop the RX FIFO head.
- `rx_empty_po`, out, 1: RX FIFO empty.
- `rx_overrun_po`, out, 1: sticky flag, a word was lost to a full RX FIFO.
- `clr_err_pi`, in, 1: clears `rx_overrun_po`.
- `parity_odd_pi`, in, 1: 0 selects even parity, 1 selects odd. Present only with the parity macro.
- `rx`, in, 1: serial input, asynchronous to `clk_in1`.
- `tx`, out, 1: serial output.

## Operation
- Tick generator: divisor `DIV = CLK_HZ / (BAUD*16)`, truncated, minimum 1. It emits a one-cycle `tick` every DIV clocks and free-runs from reset. One bit period is 16 ticks.
- TX FSM states and transitions:
  - IDLE → START when the TX FIFO is not empty. The head word is popped in the cycle of the transition.
  - START → DATA. DATA shifts out DATA_W bits, LSB first.
  - DATA → PARITY (parity macro only) → STOP.
  - STOP lasts `STOP_BITS` bit periods, then returns to IDLE.
  - Every state other than IDLE lasts 16 ticks per bit.
- RX synchronizer: two flip-flops on `rx`, reset value 1. The FSM uses only the synchronized signal.
- RX FSM states and transitions:
  - IDLE → START on a synchronized 1→0 edge. The tick counter restarts at 0.
  - START: at tick 8 the line is re-sampled. If it reads 1 (glitch), return to IDLE and push nothing. Otherwise go to DATA.
  - DATA: sample at tick 8 of each bit, shift LSB first. Then go to PARITY (macro only), then STOP.
  - STOP: sample at tick 8. `ferr = (sample == 0)`. Push `{perr, ferr, data}`, then go to IDLE.
  - A word with `ferr` set is still pushed.
- Parity bit: XOR of the data bits, XOR `parity_odd_pi`. `perr` = received parity bit ≠ computed parity.
- FIFOs are width DATA_W (TX) and DATA_W+2 (RX), with show-ahead output.
- Write when full: the TX write is dropped. For RX, the word is dropped and `rx_overrun_po` is set.
- Read when empty: ignored.
- Simultaneous push and pop on a full FIFO: both are accepted and the count is unchanged. On an empty FIFO, the pop is ignored and the push is accepted.
- `clr_err_pi` together with a new overrun: set wins.

## Timing
- Reset values: `tx`=1, `tx_full_po`=0, `tx_busy_po`=0, `rx_empty_po`=1, `rx_data_po`=0, `rx_ferr_po`=0, `rx_perr_po`=0, `rx_overrun_po`=0. Both FSMs go to IDLE and both FIFOs are emptied.
- Reset during a frame: `tx` returns to 1 immediately (asynchronously) and a partial RX word is discarded.
- `tx_wr_pi` to `tx` falling: 2 cycles when idle (FIFO write, then FSM pop) plus alignment to the next tick, at most DIV-1 further cycles.
- `tx_full_po` and `rx_empty_po` update in the cycle after the causing push or pop.
- RX stop-bit mid-sample to `rx_empty_po`=0: 2 cycles.
- Back-to-back TX frames: the next start bit follows the last stop bit with no idle gap.

## Configuration
- `UART_PARITY_EN` defined:
  - a parity bit is inserted after the data bits on TX and checked on RX;
  - the `parity_odd_pi` port exists.
- `UART_PARITY_EN` undefined:
  - frames are start + DATA_W + stop;
  - the port is absent and `rx_perr_po` is constant 0.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - `rx_state_t` {IDLE, START, DATA, PARITY, STOP};
  - localparam `OVERSAMPLE = 16` and `MID_SAMPLE = 8`.
- One sub-module, `uart_sync_fifo`, parametrised by WIDTH and DEPTH. It is instantiated twice: TX and RX.

## Test plan
Bench parameters: CLK_HZ=1_600_000, BAUD=100_000 (DIV=1, 16 cycles per bit), DATA_W=8, FIFO_DEPTH=4.
- Reset, then write 8'hAF → `tx` shows 0,1,1,1,1,0,1,0,1,1, 16 cycles per bit, then `tx_busy_po` falls.
- Drive serial 8'h5A on `rx` with a valid stop bit → `rx_empty_po`=0, `rx_data_po`=8'h5A, `rx_ferr_po`=0.
- Drive `rx`=0 for 4 cycles then back to 1 → nothing pushed, `rx_empty_po` stays 1.
- Send a frame with stop bit 0 → word pushed with `rx_ferr_po`=1. Receive 5 frames without reading → 4 entries stored, `rx_overrun_po`=1, cleared by `clr_err_pi`.
- Write 6 words back-to-back → `tx_full_po` asserts and the 6th is dropped. Frames 1-5 are sent contiguously: 1 in the serializer plus 4 buffered.
- With `UART_PARITY_EN`, `parity_odd_pi`=0: send 8'h03 with parity bit 1 → `rx_perr_po`=1. Send it with parity bit 0 → `rx_perr_po`=0. Assert `reset_pi` mid-TX-frame → `tx`=1 within the same cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for uart_fifo_core: FSM state encodings, the
// 16x oversampling constants and the baud divisor helper.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  function automatic int calc_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock show-ahead FIFO; the head word is presented while not empty and
// reads as zero when empty. A push into a full FIFO is accepted only with a pop.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             push_ok_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Accept/ignore decisions and next-state pointers and occupancy.
  always_comb begin
    do_pop_s  = pop_i && (count_q != {(AW+1){1'b0}});
    do_push_s = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop_s);
    if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else           wr_ptr_d = wr_ptr_q;
    if (do_pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
    else          rd_ptr_d = rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o    = (count_q == {(AW+1){1'b0}});
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign push_ok_o  = do_push_s;
  assign pop_data_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_fifo_core.sv
// FIFO-buffered UART transceiver with 16x oversampled receiver.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_in1,
  input  logic              reset_pi,
  input  logic [DATA_W-1:0] tx_data_pi,
  input  logic              tx_wr_pi,
  output logic              tx_full_po,
  output logic              tx_busy_po,
  output logic [DATA_W-1:0] rx_data_po,
  output logic              rx_ferr_po,
  output logic              rx_perr_po,
  input  logic              rx_rd_pi,
  output logic              rx_empty_po,
  output logic              rx_overrun_po,
  input  logic              clr_err_pi,
`ifdef UART_PARITY_EN
  input  logic              parity_odd_pi,
`endif
  input  logic              rx,
  output logic              tx
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = $clog2(DIV + 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_W - 1);
  localparam logic [0:0] LAST_STOP = 1'(STOP_BITS - 1);

  logic parity_odd_s;
`ifdef UART_PARITY_EN
  assign parity_odd_s = parity_odd_pi;
`else
  assign parity_odd_s = 1'b0;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_s;
  logic [1:0]       sync_q, sync_d;
  logic             rx_prev_q, rx_prev_d, rx_line_s, rx_fall_s;
  logic             overrun_q, overrun_d;

  tx_state_t         tx_state_q;
  logic              tx_q, tx_par_q, tx_pop_s, tx_empty_s, tx_bit_end_s, tx_push_ok_s;
  logic [DATA_W-1:0] tx_shift_q, tx_head_s;
  logic [3:0]        tx_tick_q;
  logic [2:0]        tx_bit_q;
  logic [0:0]        tx_stop_q;

  rx_state_t         rx_state_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [DATA_W+1:0] rx_word_q, rx_head_s;
  logic [3:0]        rx_tick_q;
  logic [2:0]        rx_bit_q;
  logic              rx_perr_q, rx_push_q, rx_mid_s, rx_bit_end_s, rx_full_s, rx_push_ok_s;
  logic              unused_s;

  // Tick divider, input synchronizer and sticky overrun next-state.
  always_comb begin
    tick_s    = (div_q == DIV_W'(DIV - 1));
    if (tick_s) div_d = {DIV_W{1'b0}};
    else        div_d = div_q + DIV_W'(1);
    sync_d    = {sync_q[0], rx};
    rx_prev_d = sync_q[1];
    if (rx_push_q && !rx_push_ok_s) overrun_d = 1'b1;
    else if (clr_err_pi)            overrun_d = 1'b0;
    else                            overrun_d = overrun_q;
  end

  // Divider, synchronizer and overrun flag registers.
  always_ff @(posedge clk_in1 or posedge reset_pi) begin
    if (reset_pi) begin
      div_q     <= {DIV_W{1'b0}};
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      sync_q    <= sync_d;
      rx_prev_q <= rx_prev_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_line_s    = sync_q[1];
  assign rx_fall_s    = rx_prev_q & ~rx_line_s;
  assign tx_bit_end_s = tick_s && (tx_tick_q == LAST_TICK);
  assign rx_mid_s     = tick_s && (rx_tick_q == MID_TICK);
  assign rx_bit_end_s = tick_s && (rx_tick_q == LAST_TICK);

  // Pop the next word on a tick from IDLE, or straight out of the last stop bit.
  always_comb begin
    tx_pop_s = 1'b0;
    if (tx_empty_s)                     tx_pop_s = 1'b0;
    else if (tx_state_q == TX_IDLE)     tx_pop_s = tick_s;
    else if (tx_state_q == TX_STOP)     tx_pop_s = tx_bit_end_s && (tx_stop_q == LAST_STOP);
    else                                tx_pop_s = 1'b0;
  end

  // Transmit FSM with registered serial output.
  always_ff @(posedge clk_in1 or posedge reset_pi) begin
    if (reset_pi) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_shift_q <= {DATA_W{1'b0}};
      tx_par_q   <= 1'b0;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_stop_q  <= 1'b0;
    end else if (tx_pop_s) begin
      tx_state_q <= TX_START;
      tx_q       <= 1'b0;
      tx_shift_q <= tx_head_s;
      tx_par_q   <= (^tx_head_s) ^ parity_odd_s;
      tx_tick_q  <= 4'd0;
    end else begin
      if (tick_s && tx_state_q != TX_IDLE) tx_tick_q <= tx_tick_q + 4'd1;
      case (tx_state_q)
        TX_IDLE: tx_q <= 1'b1;
        TX_START: if (tx_bit_end_s) begin
          tx_state_q <= TX_DATA;
          tx_q       <= tx_shift_q[0];
          tx_bit_q   <= 3'd0;
        end
        TX_DATA: if (tx_bit_end_s) begin
          if (tx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
            tx_state_q <= TX_PARITY;
            tx_q       <= tx_par_q;
`else
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
            tx_stop_q  <= 1'b0;
`endif
          end else begin
            tx_shift_q <= {1'b0, tx_shift_q[DATA_W-1:1]};
            tx_q       <= tx_shift_q[1];
            tx_bit_q   <= tx_bit_q + 3'd1;
          end
        end
        TX_PARITY: if (tx_bit_end_s) begin
          tx_state_q <= TX_STOP;
          tx_q       <= 1'b1;
          tx_stop_q  <= 1'b0;
        end
        TX_STOP: if (tx_bit_end_s) begin
          if (tx_stop_q == LAST_STOP) tx_state_q <= TX_IDLE;
          else                        tx_stop_q  <= tx_stop_q + 1'b1;
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
        end
      endcase
    end
  end

  // Receive FSM: mid-bit sampling, glitch rejection and word push.
  always_ff @(posedge clk_in1 or posedge reset_pi) begin
    if (reset_pi) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= {DATA_W{1'b0}};
      rx_word_q  <= {(DATA_W+2){1'b0}};
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_perr_q  <= 1'b0;
      rx_push_q  <= 1'b0;
    end else begin
      rx_push_q <= 1'b0;
      if (tick_s) rx_tick_q <= rx_tick_q + 4'd1;
      case (rx_state_q)
        RX_IDLE: if (rx_fall_s) begin
          rx_state_q <= RX_START;
          rx_tick_q  <= 4'd0;
          rx_bit_q   <= 3'd0;
          rx_perr_q  <= 1'b0;
        end
        RX_START: begin
          if (rx_mid_s && rx_line_s) rx_state_q <= RX_IDLE;
          else if (rx_bit_end_s)     rx_state_q <= RX_DATA;
        end
        RX_DATA: begin
          if (rx_mid_s) rx_shift_q <= {rx_line_s, rx_shift_q[DATA_W-1:1]};
          if (rx_bit_end_s) begin
            if (rx_bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RX_PARITY;
`else
              rx_state_q <= RX_STOP;
`endif
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_mid_s)     rx_perr_q  <= rx_line_s ^ (^rx_shift_q) ^ parity_odd_s;
          if (rx_bit_end_s) rx_state_q <= RX_STOP;
        end
        RX_STOP: if (rx_mid_s) begin
          rx_push_q  <= 1'b1;
          rx_word_q  <= {rx_perr_q, ~rx_line_s, rx_shift_q};
          rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  uart_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk_in1), .rst(reset_pi),
    .push_i(tx_wr_pi), .push_data_i(tx_data_pi),
    .pop_i(tx_pop_s), .pop_data_o(tx_head_s),
    .full_o(tx_full_po), .empty_o(tx_empty_s), .push_ok_o(tx_push_ok_s)
  );

  uart_sync_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk_in1), .rst(reset_pi),
    .push_i(rx_push_q), .push_data_i(rx_word_q),
    .pop_i(rx_rd_pi), .pop_data_o(rx_head_s),
    .full_o(rx_full_s), .empty_o(rx_empty_po), .push_ok_o(rx_push_ok_s)
  );

  assign tx            = tx_q;
  assign tx_busy_po    = (tx_state_q != TX_IDLE) || !tx_empty_s;
  assign rx_data_po    = rx_head_s[DATA_W-1:0];
  assign rx_ferr_po    = rx_head_s[DATA_W];
  assign rx_overrun_po = overrun_q;
`ifdef UART_PARITY_EN
  assign rx_perr_po    = rx_head_s[DATA_W+1];
`else
  assign rx_perr_po    = 1'b0;
`endif
  assign unused_s      = ^{tx_push_ok_s, tx_par_q, rx_full_s, rx_head_s[DATA_W+1]};

endmodule

// File: tb/tb_uart_fifo_core.sv
// Scoreboard bench for uart_fifo_core: TX frames and RX words are checked by
// monitors against queues filled by the directed stimulus.
module tb_uart_fifo_core;

`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  typedef struct {
    logic [7:0] d;
    int         gap;
  } tx_exp_t;

  logic       clk_in1 = 1'b0;
  logic       reset_pi = 1'b1;
  logic [7:0] tx_data_pi = 8'h00;
  logic       tx_wr_pi = 1'b0;
  logic       tx_full_po, tx_busy_po;
  logic [7:0] rx_data_po;
  logic       rx_ferr_po, rx_perr_po, rx_empty_po, rx_overrun_po;
  logic       rx_rd_pi = 1'b0;
  logic       clr_err_pi = 1'b0;
  logic       parity_odd_pi = 1'b0;
  logic       rx = 1'b1;
  logic       tx;

  int         n_cmp = 0;
  int         n_err = 0;
  logic       rd_en = 1'b1;
  tx_exp_t    tx_exp[$];
  logic [9:0] rx_exp[$];

  uart_fifo_core #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_W(8), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk_in1(clk_in1), .reset_pi(reset_pi),
    .tx_data_pi(tx_data_pi), .tx_wr_pi(tx_wr_pi),
    .tx_full_po(tx_full_po), .tx_busy_po(tx_busy_po),
    .rx_data_po(rx_data_po), .rx_ferr_po(rx_ferr_po), .rx_perr_po(rx_perr_po),
    .rx_rd_pi(rx_rd_pi), .rx_empty_po(rx_empty_po), .rx_overrun_po(rx_overrun_po),
    .clr_err_pi(clr_err_pi),
`ifdef UART_PARITY_EN
    .parity_odd_pi(parity_odd_pi),
`endif
    .rx(rx), .tx(tx)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic par_of(input logic [7:0] d);
    return (^d) ^ parity_odd_pi;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    logic bits [0:10];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
`ifdef UART_PARITY_EN
    bits[9]  = par_v;
    bits[10] = stop_v;
`else
    bits[9]  = stop_v;
`endif
    for (int b = 0; b < FB; b++) begin
      rx = bits[b];
      repeat (16) @(negedge clk_in1);
    end
    rx = 1'b1;
  endtask

  task automatic expect_rx(input logic [7:0] d, input logic ferr, input logic perr);
    rx_exp.push_back({perr, ferr, d});
  endtask

  task automatic wait_rx_drained(input int max_cyc);
    for (int i = 0; i < max_cyc && rx_exp.size() != 0; i++) @(negedge clk_in1);
    chk("rx_drain", rx_exp.size(), 0);
  endtask

  task automatic wait_tx_drained(input int max_cyc);
    for (int i = 0; i < max_cyc && (rx_exp.size() != 0 || tx_exp.size() != 0 || tx_busy_po); i++)
      @(negedge clk_in1);
    chk("tx_drain", tx_exp.size(), 0);
    chk("tx_idle_busy", tx_busy_po, 0);
  endtask

  // TX monitor: frames the serial line and compares every cycle of every bit.
  initial begin
    tx_exp_t e;
    logic    frame [0:10];
    logic    alive, bad;
    int      gap;
    forever begin
      gap = 0;
      @(negedge clk_in1);
      while (tx !== 1'b0 || reset_pi) begin
        gap++;
        @(negedge clk_in1);
      end
      if (tx_exp.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL tx_unexpected_frame: got a start bit expected none");
        e.d   = 8'h00;
        e.gap = -1;
      end else begin
        e = tx_exp.pop_front();
        if (e.gap >= 0) chk("tx_gap", gap, e.gap);
      end
      frame[0] = 1'b0;
      for (int i = 0; i < 8; i++) frame[1+i] = e.d[i];
`ifdef UART_PARITY_EN
      frame[9]  = (^e.d) ^ parity_odd_pi;
      frame[10] = 1'b1;
`else
      frame[9]  = 1'b1;
`endif
      alive = 1'b1;
      for (int b = 0; b < FB && alive; b++) begin
        bad = 1'b0;
        for (int c = 0; c < 16 && alive; c++) begin
          if (reset_pi) alive = 1'b0;
          else begin
            if (tx !== frame[b]) bad = 1'b1;
            if (!(b == FB - 1 && c == 15)) @(negedge clk_in1);
          end
        end
        if (alive) chk($sformatf("tx_bit%0d_of_%0h", b, e.d), bad, 0);
      end
    end
  end

  // RX monitor: pops the head whenever reading is enabled and a word is present.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk_in1);
      rx_rd_pi = 1'b0;
      if (rd_en && !reset_pi && !rx_empty_po) begin
        if (rx_exp.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected_word: got 0x%0h expected none",
                   {rx_perr_po, rx_ferr_po, rx_data_po});
        end else begin
          e = rx_exp.pop_front();
          chk("rx_word", {rx_perr_po, rx_ferr_po, rx_data_po}, e);
        end
        rx_rd_pi = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words [0:5];
    int         cnt;

    // Reset state
    repeat (3) @(negedge clk_in1);
    chk("rst_tx", tx, 1);
    chk("rst_tx_full", tx_full_po, 0);
    chk("rst_tx_busy", tx_busy_po, 0);
    chk("rst_rx_empty", rx_empty_po, 1);
    chk("rst_rx_data", rx_data_po, 0);
    chk("rst_rx_ferr", rx_ferr_po, 0);
    chk("rst_rx_perr", rx_perr_po, 0);
    chk("rst_overrun", rx_overrun_po, 0);
    reset_pi = 1'b0;
    repeat (4) @(negedge clk_in1);

    // Single TX word 8'hAF: latency and frame length
    tx_exp.push_back('{8'hAF, -1});
    tx_data_pi = 8'hAF;
    tx_wr_pi   = 1'b1;
    @(negedge clk_in1);
    tx_wr_pi = 1'b0;
    chk("tx_lat_cycle1", tx, 1);
    chk("tx_busy_after_wr", tx_busy_po, 1);
    @(negedge clk_in1);
    chk("tx_lat_cycle2", tx, 0);
    cnt = 0;
    while (tx_busy_po && cnt < 400) begin
      @(negedge clk_in1);
      cnt++;
    end
    chk("tx_frame_len", cnt, FB * 16);
    chk("tx_idle_line", tx, 1);

    // RX valid frame 8'h5A
    expect_rx(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, par_of(8'h5A));
    wait_rx_drained(100);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (4) @(negedge clk_in1);
    rx = 1'b1;
    repeat (48) @(negedge clk_in1);
    chk("glitch_empty", rx_empty_po, 1);

    // Framing error is still pushed
    expect_rx(8'hC3, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, par_of(8'hC3));
    repeat (16) @(negedge clk_in1);
    wait_rx_drained(100);

    // Overrun: five frames into a four-entry FIFO
    rd_en = 1'b0;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_rx(words[i], 1'b0, 1'b0);
      send_frame(words[i], 1'b1, par_of(words[i]));
      if (i == 3) chk("overrun_before_full", rx_overrun_po, 0);
    end
    repeat (4) @(negedge clk_in1);
    chk("overrun_set", rx_overrun_po, 1);
    chk("overrun_head_present", rx_empty_po, 0);
    clr_err_pi = 1'b1;
    @(negedge clk_in1);
    clr_err_pi = 1'b0;
    chk("overrun_cleared", rx_overrun_po, 0);
    rd_en = 1'b1;
    wait_rx_drained(100);
    repeat (4) @(negedge clk_in1);
    chk("rx_empty_after_drain", rx_empty_po, 1);

    // Six back-to-back TX writes: full asserts, sixth dropped, frames contiguous
    words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'h55;
    words[3] = 8'hAA; words[4] = 8'hFE; words[5] = 8'h7F;
    for (int i = 0; i < 5; i++) tx_exp.push_back('{words[i], (i == 0) ? -1 : 0});
    for (int i = 0; i < 6; i++) begin
      tx_data_pi = words[i];
      tx_wr_pi   = 1'b1;
      @(negedge clk_in1);
      if (i == 3) chk("tx_full_at3", tx_full_po, 0);
      if (i == 4) chk("tx_full_at4", tx_full_po, 1);
    end
    tx_wr_pi = 1'b0;
    wait_tx_drained(5 * FB * 16 + 100);
    repeat (200) @(negedge clk_in1);
    chk("tx_no_sixth", tx_exp.size(), 0);

`ifdef UART_PARITY_EN
    // Parity error detection, even parity
    parity_odd_pi = 1'b0;
    expect_rx(8'h03, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1);
    wait_rx_drained(100);
    expect_rx(8'h03, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, 1'b0);
    wait_rx_drained(100);
`endif

    // Reset in the middle of a TX and an RX frame
    fork
      send_frame(8'hFF, 1'b1, par_of(8'hFF));
      begin
        tx_exp.push_back('{8'h00, -1});
        tx_data_pi = 8'h00;
        tx_wr_pi   = 1'b1;
        @(negedge clk_in1);
        tx_wr_pi = 1'b0;
        repeat (60) @(negedge clk_in1);
        chk("tx_low_mid_frame", tx, 0);
        #1 reset_pi = 1'b1;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_busy", tx_busy_po, 0);
        repeat (3) @(negedge clk_in1);
        reset_pi = 1'b0;
      end
    join
    repeat (40) @(negedge clk_in1);
    chk("rst_rx_discard", rx_empty_po, 1);
    chk("rst_tx_idle", tx, 1);

    chk("tx_queue_left", tx_exp.size(), 0);
    chk("rx_queue_left", rx_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
